// File: rtl/alarm_seq.sv
// alarm_seq: alarm clock sequencer with time/alarm setting,
// display blink phase and bounded ring duration.
module alarm_seq #(
    parameter int CLK_HZ = 100_000_000,
    parameter int RING_S = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_hr,
    input  logic        btn_min,
    input  logic        alarm_en,
    output logic [16:0] disp_time,
    output logic        blank,
    output logic        ring,
    output logic [1:0]  mode
);
    localparam int HALF = CLK_HZ / 2;
    localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [DW-1:0] DIV_END  = DW'(HALF - 1);
    localparam logic [7:0]    RING_END = 8'(RING_S - 1);

    typedef enum logic [1:0] {
        S_RUN       = 2'd0,
        S_SET_TIME  = 2'd1,
        S_SET_ALARM = 2'd2,
        S_RINGING   = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [DW-1:0] r_div;
    logic          r_phase;
    logic [4:0]    r_hh;
    logic [4:0]    r_ahh;
    logic [5:0]    r_mm;
    logic [5:0]    r_ss;
    logic [5:0]    r_amm;
    logic [7:0]    r_rcnt;
    logic [16:0]   r_disp;
    logic          r_blank;
    logic          r_ring;
    logic [4:0]    w_hh_tk;
    logic [5:0]    w_mm_tk;
    logic [5:0]    w_ss_tk;
    logic [16:0]   w_disp_nx;
    logic          w_half;
    logic          w_sec;
    logic          w_match;
    logic          w_ring_done;
    logic          w_run;
    logic          w_set;
    logic          w_chg;

    function automatic logic [4:0] f_inc24(input logic [4:0] v);
        return (v == 5'd23) ? 5'd0 : v + 5'd1;
    endfunction

    function automatic logic [5:0] f_inc60(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    assign w_half      = (r_div == DIV_END);
    assign w_sec       = w_half & r_phase;
    assign w_run       = (r_state == S_RUN) | (r_state == S_RINGING);
    assign w_set       = (r_state == S_SET_TIME) | (r_state == S_SET_ALARM);
    assign w_chg       = (w_state_nx != r_state);
    assign w_ring_done = w_sec & (r_rcnt == RING_END);

    // Time value after one second, used both to count and to match
    always_comb begin
        w_ss_tk = f_inc60(r_ss);
        w_mm_tk = r_mm;
        w_hh_tk = r_hh;
        if (r_ss == 6'd59) begin
            w_mm_tk = f_inc60(r_mm);
            if (r_mm == 6'd59) begin
                w_hh_tk = f_inc24(r_hh);
            end
        end
    end

    assign w_match = alarm_en & w_sec & (w_ss_tk == 6'd0) &
                     (w_hh_tk == r_ahh) & (w_mm_tk == r_amm);

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_RUN: begin
                if (btn_mode) begin
                    w_state_nx = S_SET_TIME;
                end else if (w_match) begin
                    w_state_nx = S_RINGING;
                end
            end
            S_SET_TIME: begin
                if (btn_mode) w_state_nx = S_SET_ALARM;
            end
            S_SET_ALARM: begin
                if (btn_mode) w_state_nx = S_RUN;
            end
            S_RINGING: begin
                if (btn_mode | ~alarm_en | w_ring_done) begin
                    w_state_nx = S_RUN;
                end
            end
            default: w_state_nx = S_RUN;
        endcase
    end

    always_comb begin
        if (r_state == S_SET_ALARM) begin
            w_disp_nx = 17'(r_ahh) * 17'd3600 + 17'(r_amm) * 17'd60;
        end else begin
            w_disp_nx = 17'(r_hh) * 17'd3600 + 17'(r_mm) * 17'd60
                      + 17'(r_ss);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Leaving SET_TIME restarts the second so the new time starts clean
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div   <= '0;
            r_phase <= 1'b0;
        end else if ((r_state == S_SET_TIME) && w_chg) begin
            r_div   <= '0;
            r_phase <= 1'b0;
        end else if (w_half) begin
            r_div   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_div   <= r_div + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hh <= 5'd0;
            r_mm <= 6'd0;
            r_ss <= 6'd0;
        end else if ((r_state == S_RUN) && btn_mode) begin
            r_ss <= 6'd0;
        end else if (w_run && w_sec) begin
            r_hh <= w_hh_tk;
            r_mm <= w_mm_tk;
            r_ss <= w_ss_tk;
        end else if ((r_state == S_SET_TIME) && !btn_mode) begin
            if (btn_hr)  r_hh <= f_inc24(r_hh);
            if (btn_min) r_mm <= f_inc60(r_mm);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ahh <= 5'd7;
            r_amm <= 6'd0;
        end else if ((r_state == S_SET_ALARM) && !btn_mode) begin
            if (btn_hr)  r_ahh <= f_inc24(r_ahh);
            if (btn_min) r_amm <= f_inc60(r_amm);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rcnt <= 8'd0;
        end else if (r_state != S_RINGING) begin
            r_rcnt <= 8'd0;
        end else if (w_sec) begin
            r_rcnt <= r_rcnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_disp  <= 17'd0;
            r_blank <= 1'b0;
            r_ring  <= 1'b0;
        end else begin
            r_disp <= w_disp_nx;
            r_ring <= (w_state_nx == S_RINGING);
            if (w_chg || !w_set) begin
                r_blank <= 1'b0;
            end else if (w_half) begin
                r_blank <= ~r_blank;
            end
        end
    end

    assign disp_time = r_disp;
    assign blank     = r_blank;
    assign ring      = r_ring;
    assign mode      = r_state;
endmodule
